// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the execute-stage ALU issue path.
//   XLEN / INSTR_W     operand width and one-hot instruction vector width
//   ALU_*              one-hot instruction codes (bits 10 and 11 are unassigned)
//   ALU_LEGAL_MASK     set of bit positions that form a legal single-hot code
//   req_id_e           requester identifier
//   iss_t / res_t      contents of the issue and result registers
package alu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 37;

  localparam logic [INSTR_W-1:0] ALU_ADD   = 37'h1;
  localparam logic [INSTR_W-1:0] ALU_SUB   = 37'h2;
  localparam logic [INSTR_W-1:0] ALU_XOR   = 37'h4;
  localparam logic [INSTR_W-1:0] ALU_OR    = 37'h8;
  localparam logic [INSTR_W-1:0] ALU_AND   = 37'h10;
  localparam logic [INSTR_W-1:0] ALU_SLL   = 37'h20;
  localparam logic [INSTR_W-1:0] ALU_SRL   = 37'h40;
  localparam logic [INSTR_W-1:0] ALU_SRA   = 37'h80;
  localparam logic [INSTR_W-1:0] ALU_SLT   = 37'h100;
  localparam logic [INSTR_W-1:0] ALU_SLTU  = 37'h200;
  localparam logic [INSTR_W-1:0] ALU_ADDI  = 37'h1000;
  localparam logic [INSTR_W-1:0] ALU_SLTI  = 37'h2000;
  localparam logic [INSTR_W-1:0] ALU_XORI  = 37'h4000;
  localparam logic [INSTR_W-1:0] ALU_ORI   = 37'h8000;
  localparam logic [INSTR_W-1:0] ALU_ANDI  = 37'h10000;
  localparam logic [INSTR_W-1:0] ALU_SLLI  = 37'h20000;
  localparam logic [INSTR_W-1:0] ALU_SLTIU = 37'h40000;

  localparam logic [INSTR_W-1:0] ALU_LEGAL_MASK = 37'h7F3FF;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_e;

  typedef struct packed {
    logic               valid;
    logic               id;
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    v1;
    logic [XLEN-1:0]    v2;
  } iss_t;

  typedef struct packed {
    logic            valid;
    logic            id;
    logic [XLEN-1:0] data;
    logic            illegal;
  } res_t;

endpackage

// File: rtl/alu_issue_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, rst   clock and synchronous active-high reset
//   req[1:0]   request vector (bit i = requester i valid)
//   advance    a grant is being consumed this cycle; updates the priority
//   gnt[1:0]   one-hot grant, zero when nothing requests
// The last winner is held in last_id_q; on contention the other requester
// wins. Reset leaves last_id at requester 1 so requester 0 wins first.
module rr_arb2
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  req_id_e last_id_q;
  req_id_e last_id_d;

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_id_q == REQ1) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  always_comb begin
    last_id_d = last_id_q;
    if (advance && (gnt != 2'b00)) begin
      last_id_d = gnt[1] ? REQ1 : REQ0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_id_q <= REQ1;
    end else begin
      last_id_q <= last_id_d;
    end
  end

endmodule

// File: rtl/alu_issue_arbiter.sv
// alu_issue_arbiter: arbitrates two requesters onto the shared integer ALU.
//   req{0,1}_valid/ready/instr/v1/v2   requester handshakes and payloads
//   alu_instr/alu_v1/alu_v2            issue-register contents driving the ALU
//   alu_result                         combinational ALU output
//   resp_valid/ready/id/data/illegal   result-register response handshake
// Two registered stages: issue (feeds the ALU) and result (captures the ALU
// output). Each stage advances whenever its downstream stage is free, so a
// full pipe with resp_ready=1 moves one op per cycle.
module alu_issue_arbiter
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [INSTR_W-1:0] req0_instr,
  input  logic [XLEN-1:0]    req0_v1,
  input  logic [XLEN-1:0]    req0_v2,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [INSTR_W-1:0] req1_instr,
  input  logic [XLEN-1:0]    req1_v1,
  input  logic [XLEN-1:0]    req1_v2,
  output logic [INSTR_W-1:0] alu_instr,
  output logic [XLEN-1:0]    alu_v1,
  output logic [XLEN-1:0]    alu_v2,
  input  logic [XLEN-1:0]    alu_result,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic               resp_id,
  output logic [XLEN-1:0]    resp_data,
  output logic               resp_illegal
);

  // Legal means exactly one bit set, and that bit inside the legal mask.
  function automatic logic is_legal(input logic [INSTR_W-1:0] code);
    return (code != '0) &&
           ((code & (code - INSTR_W'(1))) == '0) &&
           ((code & ~ALU_LEGAL_MASK) == '0);
  endfunction

  iss_t iss_q, iss_d;
  res_t res_q, res_d;

  logic       res_free;
  logic       iss_free;
  logic       accept;
  logic       capture;
  logic [1:0] gnt;

  assign res_free = !res_q.valid || resp_ready;
  assign iss_free = !iss_q.valid || res_free;
  assign capture  = iss_q.valid && res_free;
  assign accept   = iss_free && (gnt != 2'b00);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (iss_free),
    .gnt     (gnt)
  );

  assign req0_ready = iss_free && gnt[0];
  assign req1_ready = iss_free && gnt[1];

  // Issue stage: a new accept overwrites a departing op in the same cycle.
  always_comb begin
    iss_d = iss_q;
    if (accept) begin
      iss_d.valid = 1'b1;
      iss_d.id    = gnt[1];
      iss_d.instr = gnt[1] ? req1_instr : req0_instr;
      iss_d.v1    = gnt[1] ? req1_v1    : req0_v1;
      iss_d.v2    = gnt[1] ? req1_v2    : req0_v2;
    end else if (capture) begin
      iss_d.valid = 1'b0;
    end
  end

  // Result stage: a capture overwrites a result being handed off this cycle.
  always_comb begin
    res_d = res_q;
    if (capture) begin
      res_d.valid   = 1'b1;
      res_d.id      = iss_q.id;
      res_d.data    = alu_result;
      res_d.illegal = !is_legal(iss_q.instr);
    end else if (res_q.valid && resp_ready) begin
      res_d.valid = 1'b0;
    end
  end

  // Data fields are cleared too so the ALU and response ports read zero after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      iss_q <= '0;
      res_q <= '0;
    end else begin
      iss_q <= iss_d;
      res_q <= res_d;
    end
  end

  assign alu_instr    = iss_q.instr;
  assign alu_v1       = iss_q.v1;
  assign alu_v2       = iss_q.v2;
  assign resp_valid   = res_q.valid;
  assign resp_id      = res_q.id;
  assign resp_data    = res_q.data;
  assign resp_illegal = res_q.illegal;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// tb_alu_issue_arbiter: scoreboard bench for alu_issue_arbiter.
// A driver feeds per-requester op queues, a negedge monitor predicts ready
// and response behaviour from an occupancy/round-robin model and compares.
module tb_alu_issue_arbiter;
  import alu_pkg::*;

  logic               clk;
  logic               rst;
  logic               req0_valid, req0_ready;
  logic [INSTR_W-1:0] req0_instr;
  logic [XLEN-1:0]    req0_v1, req0_v2;
  logic               req1_valid, req1_ready;
  logic [INSTR_W-1:0] req1_instr;
  logic [XLEN-1:0]    req1_v1, req1_v2;
  logic [INSTR_W-1:0] alu_instr;
  logic [XLEN-1:0]    alu_v1, alu_v2;
  logic [XLEN-1:0]    alu_result;
  logic               resp_valid, resp_ready, resp_id, resp_illegal;
  logic [XLEN-1:0]    resp_data;

  alu_issue_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_instr(req0_instr),
    .req0_v1(req0_v1), .req0_v2(req0_v2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_instr(req1_instr),
    .req1_v1(req1_v1), .req1_v2(req1_v2),
    .alu_instr(alu_instr), .alu_v1(alu_v1), .alu_v2(alu_v2), .alu_result(alu_result),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_data(resp_data), .resp_illegal(resp_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    v1;
    logic [XLEN-1:0]    v2;
  } op_t;

  typedef struct {
    logic            id;
    logic [XLEN-1:0] data;
    logic            ill;
    int              acc;
  } exp_t;

  op_t  pend0[$];
  op_t  pend1[$];
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit last_w = 1'b1;
  bit acc0   = 1'b0;
  bit acc1   = 1'b0;
  bit did_rst = 1'b0;
  bit rr_rand = 1'b0;
  bit rr_val  = 1'b1;
  bit gap_en  = 1'b0;

  logic [INSTR_W-1:0] codes [16];

  // Behavioural ALU: drives alu_result and also gives expected data.
  function automatic logic [XLEN-1:0] ref_alu(input logic [INSTR_W-1:0] c,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    case (c)
      ALU_ADD:  return a + b;
      ALU_SUB:  return a - b;
      ALU_XOR:  return a ^ b;
      ALU_OR:   return a | b;
      ALU_AND:  return a & b;
      ALU_SLL:  return a << b[4:0];
      ALU_SRL:  return a >> b[4:0];
      ALU_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      ALU_SLT:  return {31'd0, $signed(a) < $signed(b)};
      ALU_SLTU: return {31'd0, a < b};
      default:  return '0;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [INSTR_W-1:0] c);
    if ($countones(c) != 1) return 1'b0;
    for (int i = 0; i < INSTR_W; i++)
      if (c[i]) return (i <= 9) || (i >= 12 && i <= 18);
    return 1'b0;
  endfunction

  function automatic op_t mk(input logic [INSTR_W-1:0] c, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b);
    op_t o;
    o.instr = c; o.v1 = a; o.v2 = b;
    return o;
  endfunction

  function automatic op_t rnd_op();
    logic [XLEN-1:0] a, b;
    a = ($urandom_range(0, 1) != 0) ? $urandom : XLEN'($urandom_range(0, 40));
    b = ($urandom_range(0, 1) != 0) ? $urandom : XLEN'($urandom_range(0, 40));
    return mk(codes[$urandom_range(0, 15)], a, b);
  endfunction

  always_comb alu_result = ref_alu(alu_instr, alu_v1, alu_v2);

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Driver: holds valid/payload until the model reports acceptance.
  always begin
    bit h0, h1;
    @(posedge clk);
    #1;
    if (acc0 && pend0.size() > 0) pend0.delete(0);
    if (acc1 && pend1.size() > 0) pend1.delete(0);
    h0 = req0_valid && !acc0;
    h1 = req1_valid && !acc1;
    acc0 = 1'b0;
    acc1 = 1'b0;
    if (pend0.size() > 0 && (h0 || !gap_en || $urandom_range(0, 3) != 0)) begin
      req0_valid = 1'b1; req0_instr = pend0[0].instr; req0_v1 = pend0[0].v1; req0_v2 = pend0[0].v2;
    end else begin
      req0_valid = 1'b0;
    end
    if (pend1.size() > 0 && (h1 || !gap_en || $urandom_range(0, 3) != 0)) begin
      req1_valid = 1'b1; req1_instr = pend1[0].instr; req1_v1 = pend1[0].v1; req1_v2 = pend1[0].v2;
    end else begin
      req1_valid = 1'b0;
    end
    resp_ready = rr_rand ? ($urandom_range(0, 1) != 0) : rr_val;
  end

  // Monitor/model: occupancy decides readiness, round-robin decides the winner,
  // and the oldest op becomes visible one edge after its accept edge.
  always @(negedge clk) begin
    bit   free, win, e0, e1, erv;
    exp_t e;
    if (did_rst) begin
      check("rst_alu_instr", 64'(alu_instr), 64'd0);
      check("rst_alu_v1", 64'(alu_v1), 64'd0);
      check("rst_alu_v2", 64'(alu_v2), 64'd0);
      check("rst_resp", {resp_valid, resp_id, resp_illegal, resp_data}, 64'd0);
    end
    if (rst) begin
      sb.delete();
      last_w  = 1'b1;
      acc0    = 1'b0;
      acc1    = 1'b0;
      did_rst = 1'b1;
    end else begin
      did_rst = 1'b0;
      free = (sb.size() < 2) || resp_ready;
      win  = (req0_valid && req1_valid) ? !last_w : req1_valid;
      e0   = req0_valid && free && !win;
      e1   = req1_valid && free && win;
      check("req_ready", {62'd0, req1_ready, req0_ready}, {62'd0, e1, e0});
      erv = (sb.size() > 0) && (sb[0].acc < cyc);
      check("resp_valid", 64'(resp_valid), 64'(erv));
      if (erv && resp_valid) begin
        check("resp_id", 64'(resp_id), 64'(sb[0].id));
        check("resp_data", 64'(resp_data), 64'(sb[0].data));
        check("resp_illegal", 64'(resp_illegal), 64'(sb[0].ill));
      end
      if (erv && resp_ready) sb.delete(0);
      if (e0 || e1) begin
        e.id   = win;
        e.data = win ? ref_alu(req1_instr, req1_v1, req1_v2) : ref_alu(req0_instr, req0_v1, req0_v2);
        e.ill  = win ? !ref_legal(req1_instr) : !ref_legal(req0_instr);
        e.acc  = cyc + 1;
        sb.push_back(e);
        last_w = win;
        if (win) acc1 = 1'b1; else acc0 = 1'b1;
      end
    end
  end

  task automatic drain(input string nm, input int max);
    int n = 0;
    while ((pend0.size() > 0 || pend1.size() > 0 || sb.size() > 0) && n < max) begin
      @(posedge clk);
      n++;
    end
    if (n >= max) begin
      checks++;
      errors++;
      $display("FAIL drain_%s: pipeline still busy after %0d cycles, expected empty", nm, max);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    pend0.delete();
    pend1.delete();
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic [INSTR_W-1:0] one;
    one = INSTR_W'(1);
    for (int i = 0; i < 10; i++) codes[i] = one << i;
    codes[10] = ALU_ADDI;
    codes[11] = ALU_SLTIU;
    codes[12] = '0;
    codes[13] = 37'h3;
    codes[14] = one << 10;
    codes[15] = one << 30;
    rst = 1'b1;
    req0_valid = 1'b0; req0_instr = '0; req0_v1 = '0; req0_v2 = '0;
    req1_valid = 1'b0; req1_instr = '0; req1_v1 = '0; req1_v2 = '0;
    resp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    @(posedge clk);
    pend0.push_back(mk(ALU_ADD, 32'd5, 32'd7));
    drain("single", 50);

    do_reset();
    for (int i = 0; i < 4; i++) begin
      pend0.push_back(mk(ALU_SUB, 32'd9, 32'd4));
      pend1.push_back(mk(ALU_XOR, 32'hF0, 32'h0F));
    end
    drain("contention", 60);

    rr_val = 1'b0;
    for (int i = 0; i < 4; i++) pend0.push_back(mk(ALU_ADD, 32'(i * 100), 32'd3));
    repeat (5) @(posedge clk);
    rr_val = 1'b1;
    drain("backpressure", 60);

    pend1.push_back(mk(37'h3, 32'd11, 32'd22));
    pend1.push_back(mk(ALU_ADD, 32'd11, 32'd22));
    drain("illegal", 60);

    pend0.push_back(mk(ALU_SLL, 32'd1, 32'd4));
    pend0.push_back(mk(ALU_SLL, 32'd1, 32'd31));
    drain("sll", 60);

    rr_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      pend0.push_back(mk(ALU_OR, 32'h100, 32'(i)));
      pend1.push_back(mk(ALU_AND, 32'hFF, 32'h0F));
    end
    repeat (4) @(posedge clk);
    do_reset();
    rr_val = 1'b1;
    pend0.push_back(mk(ALU_SRA, 32'h80000000, 32'd4));
    pend1.push_back(mk(ALU_SLT, 32'hFFFFFFFF, 32'd1));
    drain("post_reset", 60);

    rr_rand = 1'b1;
    gap_en  = 1'b1;
    for (int i = 0; i < 200; i++) begin
      pend0.push_back(rnd_op());
      pend1.push_back(rnd_op());
    end
    drain("random", 20000);
    rr_rand = 1'b0;
    gap_en  = 1'b0;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1, "timeout");
  end

endmodule
